// File: rtl/fetch_ctrl_if.sv
// Instruction-memory port and decode hand-off bundle for fetch_ctrl.
// master = fetch controller, slave = memory / decode side.
interface fetch_ctrl_if;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        inst_valid;
  logic [31:0] inst;
  logic [31:0] inst_pc;
  logic        inst_ready;

  modport master (
    output imem_req, imem_addr,
    input  imem_gnt, imem_rvalid, imem_rdata,
    output inst_valid, inst, inst_pc,
    input  inst_ready
  );

  modport slave (
    input  imem_req, imem_addr,
    output imem_gnt, imem_rvalid, imem_rdata,
    input  inst_valid, inst, inst_pc,
    output inst_ready
  );
endinterface

// File: rtl/fetch_ctrl.sv
// RV32I fetch controller: sequences pc, issues one outstanding imem request, buffers for decode.
// FETCH_CTRL_MISALIGN_TRAP_EN enables the FAULT state for misaligned redirect targets.
module fetch_ctrl #(
  parameter logic [31:0] RESET_VECTOR = 32'h0000_0000
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [31:0]      pc,
  output logic             pc_jump_enable,
  output logic [31:0]      pc_jump_addr,
  input  logic             redirect_valid,
  input  logic [31:0]      redirect_addr,
  input  logic             trap_valid,
  input  logic [31:0]      trap_addr,
  fetch_ctrl_if.master     bus,
  output logic             fetch_misalign,
  output logic [31:0]      fetch_bad_addr
);

`ifdef FETCH_CTRL_MISALIGN_TRAP_EN
  typedef enum logic [1:0] {
    ST_RST   = 2'd0,
    ST_REQ   = 2'd1,
    ST_WAIT  = 2'd2,
    ST_FAULT = 2'd3
  } state_e;
`else
  typedef enum logic [1:0] {
    ST_RST  = 2'd0,
    ST_REQ  = 2'd1,
    ST_WAIT = 2'd2
  } state_e;
`endif

  state_e      state_q, state_d;
  logic        discard_q, discard_d;
  logic [31:0] req_pc_q, req_pc_d;
  logic        inst_valid_q;
  logic [31:0] inst_q, inst_pc_q;
  logic        redir, buf_free, load, req;
  logic [31:0] tgt_raw, tgt;

  // Trap wins over execute redirect
  assign redir   = trap_valid | redirect_valid;
  assign tgt_raw = trap_valid ? trap_addr : redirect_addr;

`ifdef FETCH_CTRL_MISALIGN_TRAP_EN
  logic bad_tgt;
  assign tgt     = tgt_raw;
  assign bad_tgt = redir && (tgt_raw[1:0] != 2'b00);
`else
  logic unused_tgt_lo;
  assign tgt           = {tgt_raw[31:2], 2'b00};
  assign unused_tgt_lo = ^tgt_raw[1:0];
`endif

  // Buffer can take a new response if empty or drained this cycle
  assign buf_free       = !inst_valid_q || bus.inst_ready;
  assign bus.imem_req   = req;
  assign bus.imem_addr  = pc;
  assign bus.inst_valid = inst_valid_q;
  assign bus.inst       = inst_q;
  assign bus.inst_pc    = inst_pc_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= ST_RST;
      discard_q <= 1'b0;
      req_pc_q  <= 32'h0;
    end else begin
      state_q   <= state_d;
      discard_q <= discard_d;
      req_pc_q  <= req_pc_d;
    end
  end

  // The pc module self-increments, so every non-advancing cycle re-loads pc
  always_comb begin
    state_d        = state_q;
    discard_d      = discard_q;
    req_pc_d       = req_pc_q;
    load           = 1'b0;
    req            = 1'b0;
    pc_jump_enable = 1'b1;
    pc_jump_addr   = pc;
    case (state_q)
      ST_RST: begin
        pc_jump_addr = RESET_VECTOR;
        state_d      = ST_REQ;
      end
      ST_REQ: begin
        req = buf_free;
        if (buf_free && bus.imem_gnt) begin
          pc_jump_enable = 1'b0;
          req_pc_d       = pc;
          discard_d      = redir;
          state_d        = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (bus.imem_rvalid) begin
          load      = !discard_q && !redir;
          discard_d = 1'b0;
          state_d   = ST_REQ;
        end else if (redir) begin
          discard_d = 1'b1;
        end
      end
`ifdef FETCH_CTRL_MISALIGN_TRAP_EN
      ST_FAULT: begin
        if (bus.imem_rvalid) discard_d = 1'b0;
        if (redir) state_d = ST_REQ;
      end
`endif
      default: state_d = ST_RST;
    endcase
    if (redir) begin
      pc_jump_enable = 1'b1;
      pc_jump_addr   = tgt;
    end
`ifdef FETCH_CTRL_MISALIGN_TRAP_EN
    if (bad_tgt) state_d = ST_FAULT;
`endif
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      inst_valid_q <= 1'b0;
      inst_q       <= 32'h0;
      inst_pc_q    <= 32'h0;
    end else begin
      if (redir) begin
        inst_valid_q <= 1'b0;
      end else if (load) begin
        inst_valid_q <= 1'b1;
      end else if (bus.inst_ready) begin
        inst_valid_q <= 1'b0;
      end
      if (load) begin
        inst_q    <= bus.imem_rdata;
        inst_pc_q <= req_pc_q;
      end
    end
  end

`ifdef FETCH_CTRL_MISALIGN_TRAP_EN
  logic        misalign_q;
  logic [31:0] bad_addr_q;

  // Bad address stays visible until the next redirect replaces or clears it
  always_ff @(posedge clk) begin
    if (reset) begin
      misalign_q <= 1'b0;
      bad_addr_q <= 32'h0;
    end else begin
      misalign_q <= bad_tgt;
      if (redir) bad_addr_q <= bad_tgt ? tgt : 32'h0;
    end
  end

  assign fetch_misalign = misalign_q;
  assign fetch_bad_addr = bad_addr_q;
`else
  assign fetch_misalign = 1'b0;
  assign fetch_bad_addr = 32'h0;
`endif

endmodule
